// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the HI/LO registers.
// Handles MULT, MULTU, DIV and DIVU with a start/busy/done handshake.
// Operands are converted to magnitudes on accept and processed one bit per cycle.
// Signs are restored in a final FIX cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] acc_hi;    // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend-quotient shift register
    logic [WIDTH-1:0] mag_b;     // |multiplier| or |divisor|
    logic             is_div;
    logic             neg_q;     // product or quotient must be negated
    logic             neg_r;     // remainder must be negated
    logic [CW-1:0]    count;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             zero_div;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand decode, magnitudes and handshake status
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & src_a[WIDTH-1];
        b_neg     = signed_op & src_b[WIDTH-1];
        a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
        zero_div  = op[1] && (src_b == '0);
        last_iter = (count == CW'(1));
        busy      = (state != IDLE);
    end

    // One shift-add or restoring subtract-shift step, plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        if (is_div) begin
            // Bit WIDTH of the difference is the borrow: remainder < 2*divisor always
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end

        prod_fix = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        if (is_div) begin
            fix_lo = neg_q ? (~acc_lo + 1'b1) : acc_lo;
            fix_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort wins over completion in RUN and FIX
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !zero_div) state_next = RUN;
            RUN:     if (abort) state_next = IDLE;
                     else if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, result registers and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (zero_div) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            div_zero <= 1'b0;
                            acc_hi   <= '0;
                            acc_lo   <= a_mag;
                            mag_b    <= b_mag;
                            is_div   <= op[1];
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            count    <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    if (!abort) begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count - CW'(1);
                    end
                end
                FIX: begin
                    if (!abort) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch from just after an edge, wait for done (bounded), return results
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output logic rdz, output int lat);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clock); #1;
        start = 1'b0;
        src_a = 32'h5A5A_A5A5;
        src_b = 32'hDEAD_BEEF;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout waiting for done: got none expected done");
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        rh  = hi;
        rl  = lo;
        rdz = div_zero;
    endtask

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        logic        rdz;
        int          lat;
        int          done_seen;

        errors = 0;
        checks = 0;
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vecs[6]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{OP_DIV,   32'd3,         32'd5,         32'd3,         32'd0};
        vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        // Reset state
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven vectors, each launched back-to-back on the previous done cycle
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rdz, lat);
            chk($sformatf("vec%0d_hi", i), {32'd0, rh}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, rl}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d_div_zero", i), {63'd0, rdz}, 64'd0);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
        end

        // Back-to-back: start held on the done cycle
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rdz, lat);
        run_op(OP_MULTU, 32'd2, 32'd3, rh, rl, rdz, lat);
        chk("b2b_hi", {32'd0, rh}, 64'd0);
        chk("b2b_lo", {32'd0, rl}, 64'd6);
        chk("b2b_latency", 64'(lat), 64'd33);

        // start while busy is ignored (would otherwise be a divide-by-zero)
        start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd4;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clock); #1;
        end
        start = 1'b1; op = OP_DIV; src_a = 32'd77; src_b = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ignored_start_no_dz", {63'd0, div_zero}, 64'd0);
        chk("ignored_start_busy", {63'd0, busy}, 64'd1);
        lat = -1;
        for (int k = 6; k <= 60; k++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("ignored_start_latency", 64'(lat), 64'd33);
        chk("ignored_start_lo", {32'd0, lo}, 64'd20);
        chk("ignored_start_hi", {32'd0, hi}, 64'd0);

        // Establish hi=1, lo=6 before the divide-by-zero
        run_op(OP_DIVU, 32'd19, 32'd3, rh, rl, rdz, lat);
        chk("pre_dz_hi", {32'd0, rh}, 64'd1);
        chk("pre_dz_lo", {32'd0, rl}, 64'd6);

        // Divide by zero: done and flag one edge after start, no busy
        start = 1'b1; op = OP_DIV; src_a = 32'd5; src_b = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        chk("dz_done", {63'd0, done}, 64'd1);
        chk("dz_flag", {63'd0, div_zero}, 64'd1);
        chk("dz_busy", {63'd0, busy}, 64'd0);
        chk("dz_hi", {32'd0, hi}, 64'd1);
        chk("dz_lo", {32'd0, lo}, 64'd6);
        @(posedge clock); #1;
        chk("dz_done_pulse", {63'd0, done}, 64'd0);
        chk("dz_flag_holds", {63'd0, div_zero}, 64'd1);
        chk("dz_busy_after", {63'd0, busy}, 64'd0);

        // Next accepted MULT clears the flag
        run_op(OP_MULT, 32'd2, 32'd2, rh, rl, rdz, lat);
        chk("clear_dz_flag", {63'd0, rdz}, 64'd0);
        chk("clear_dz_lo", {32'd0, rl}, 64'd4);
        chk("clear_dz_hi", {32'd0, rh}, 64'd0);

        // Abort raised after edge 10, idle after edge 11, no done, hi/lo untouched
        start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd4);

        // Asynchronous reset mid-operation
        start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("areset_busy", {63'd0, busy}, 64'd0);
        chk("areset_hi", {32'd0, hi}, 64'd0);
        chk("areset_lo", {32'd0, lo}, 64'd0);
        chk("areset_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) done_seen++;
        end
        chk("areset_no_done", 64'(done_seen), 64'd0);
        chk("areset_idle", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
